// File: rtl/itype_multicycle_datapath_if.sv
// Instruction/debug/result bundle for the multi-cycle OP-IMM datapath.
// The master drives instructions and preloads; the slave returns results.
interface itype_multicycle_datapath_if #(parameter int XLEN = 64);
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            dbg_we;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic [XLEN-1:0] ans;
    logic            ans_valid;
    logic            illegal;

    modport master (
        output instr, instr_valid, dbg_we, dbg_addr, dbg_wdata,
        input  instr_ready, ans, ans_valid, illegal
    );

    modport slave (
        input  instr, instr_valid, dbg_we, dbg_addr, dbg_wdata,
        output instr_ready, ans, ans_valid, illegal
    );
endinterface

// File: rtl/itype_multicycle_datapath.sv
// Multi-cycle RISC-V OP-IMM datapath (addi..srai) with private register file,
// valid/ready instruction intake and a debug preload port.
module itype_multicycle_datapath #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input logic                      clk,
    input logic                      rst,
    itype_multicycle_datapath_if.slave bus
);
    localparam int S  = (XLEN == 64) ? 6 : 5;
    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [31:0]            ir_p0;
    logic [XLEN-1:0]        rf [NREG];
    logic signed [XLEN-1:0] op_a_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic signed [XLEN-1:0] result_p2;
    logic signed [XLEN-1:0] alu;
    logic signed [XLEN-1:0] rs1_val;
    logic signed [XLEN-1:0] imm_sx;
    logic [5:0]             shamt;
    logic                   legal;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [11:0] imm12;

    assign opcode = ir_p0[6:0];
    assign rd     = ir_p0[11:7];
    assign funct3 = ir_p0[14:12];
    assign rs1    = ir_p0[19:15];
    assign imm12  = ir_p0[31:20];

    function automatic logic reg_ok(input logic [4:0] r);
        return int'(r) < NREG;
    endfunction

    // Shift encodings: imm[11:S] must be all-zero, or 0100000.. for srai.
    function automatic logic shift_ok(input logic [2:0] f3, input logic [11:0] imm);
        logic [11:0] hi;
        hi = imm >> S;
        case (f3)
            3'b001:  return hi == 12'd0;
            3'b101:  return (hi == 12'd0) || (hi == (12'h400 >> S));
            default: return 1'b1;
        endcase
    endfunction

    assign legal   = (opcode == 7'b0010011) && reg_ok(rd) && reg_ok(rs1)
                     && shift_ok(funct3, imm12);
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1[AW-1:0]];
    assign imm_sx  = {{(XLEN-12){imm12[11]}}, imm12};
    assign shamt   = (S == 6) ? imm_p1[5:0] : {1'b0, imm_p1[4:0]};

    assign bus.instr_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.instr_valid) state_nxt = DECODE;
            DECODE:  state_nxt = legal ? EXEC : IDLE;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu = '0;
        case (funct3)
            3'b000:  alu = op_a_p1 + imm_p1;
            3'b010:  alu[0] = (op_a_p1 < imm_p1);
            3'b011:  alu[0] = ($unsigned(op_a_p1) < $unsigned(imm_p1));
            3'b100:  alu = op_a_p1 ^ imm_p1;
            3'b110:  alu = op_a_p1 | imm_p1;
            3'b111:  alu = op_a_p1 & imm_p1;
            3'b001:  alu = op_a_p1 << shamt;
            3'b101:  alu = imm12[10] ? (op_a_p1 >>> shamt)
                                     : $signed($unsigned(op_a_p1) >> shamt);
            default: alu = '0;
        endcase
    end

    // p0: instruction latch on accept
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.instr_valid) ir_p0 <= bus.instr;
    end

    // p1: operand fetch in DECODE; p2: ALU result in EXEC
    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            op_a_p1 <= rs1_val;
            imm_p1  <= imm_sx;
        end
        if (state == EXEC) result_p2 <= alu;
    end

    // Architectural state: register file and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ans       <= '0;
            bus.ans_valid <= 1'b0;
            bus.illegal   <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            bus.ans_valid <= 1'b0;
            bus.illegal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dbg_we && bus.dbg_addr != 5'd0 && reg_ok(bus.dbg_addr))
                        rf[bus.dbg_addr[AW-1:0]] <= bus.dbg_wdata;
                end
                DECODE: bus.illegal <= !legal;
                WB: begin
                    if (rd != 5'd0) rf[rd[AW-1:0]] <= result_p2;
                    bus.ans       <= result_p2;
                    bus.ans_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
